// File: rtl/pclk_lock_monitor.sv
// pclk_lock_monitor
//   Post-lock supervisor for the PCLK phase-alignment loop. After AlignLock
//   rises it waits SETTLE_CYC cycles, captures the settled sampled level of
//   PCLK_Slave over one window, then checks every window for drift. After
//   BAD_WIN_MAX consecutive bad windows (or CAP_RETRY ambiguous captures) it
//   raises realign_req until the sequencer acknowledges.
//
// Ports
//   rst           in   async reset, active-high
//   PCLK_Master   in   monitor clock
//   PCLK_Slave    in   supervised clock, sampled as data
//   AlignLock     in   aligner lock flag (asynchronous)
//   realign_ack   in   sequencer acknowledge level (asynchronous)
//   lock_ok       out  1 only while in MONITOR
//   ref_level     out  captured reference level of the sampled slave clock
//   drift_flag    out  sticky bad-window flag, cleared on entry to CAPTURE
//   realign_req   out  realignment request, high only in REQ
//   bad_win_cnt   out  consecutive bad-window count (saturates at 15)
//   peak_mismatch out  largest per-window mismatch count since CAPTURE entry
//   state_dbg     out  current FSM state encoding
//
// Request handshake: realign_req rises on entry to REQ and holds until the
// synchronised realign_ack is seen high, then drops (WAIT_DROP). The monitor
// only returns to IDLE once both AlignLock and realign_ack are seen low, so a
// new request cannot be raised before the sequencer has released its ack.
module pclk_lock_monitor #(
  parameter int WIN_LOG2    = 7,
  parameter int GLITCH_MAX  = 4,
  parameter int BAD_WIN_MAX = 3,
  parameter int SETTLE_CYC  = 256,
  parameter int CAP_RETRY   = 3
) (
  input  logic                rst,
  input  logic                PCLK_Master,
  input  logic                PCLK_Slave,
  input  logic                AlignLock,
  input  logic                realign_ack,
  output logic                lock_ok,
  output logic                ref_level,
  output logic                drift_flag,
  output logic                realign_req,
  output logic [3:0]          bad_win_cnt,
  output logic [WIN_LOG2:0]   peak_mismatch,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_MONITOR   = 3'd3,
    ST_REQ       = 3'd4,
    ST_WAIT_DROP = 3'd5
  } state_t;

  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] GLITCH_LIM  = CW'(GLITCH_MAX);
  localparam logic [CW-1:0] HIGH_LIM    = CW'((1 << WIN_LOG2) - GLITCH_MAX);
  localparam logic [3:0]    BAD_LIM     = 4'(BAD_WIN_MAX);
  localparam logic [3:0]    RETRY_LIM   = 4'(CAP_RETRY);
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYC - 1);

  state_t              state;
  logic [1:0]          slave_sync, lock_sync, ack_sync;
  logic [WIN_LOG2-1:0] win_cnt;
  logic                win_done;   // high in the cycle after the last window cycle
  logic [CW-1:0]       mis_cnt;    // holds the final window count while win_done
  logic [15:0]         settle_cnt;
  logic [3:0]          retry_cnt;

  logic s_slave, s_lock, s_ack;
  logic mon_sample, cap_low, cap_high, win_bad;
  logic [3:0]    bad_next, retry_next;
  logic [CW-1:0] slave_ext, mon_ext, new_ref_ext;

  assign s_slave = slave_sync[1];
  assign s_lock  = lock_sync[1];
  assign s_ack   = ack_sync[1];

  assign mon_sample  = s_slave ^ ref_level;
  assign slave_ext   = {{WIN_LOG2{1'b0}}, s_slave};
  assign mon_ext     = {{WIN_LOG2{1'b0}}, mon_sample};
  // First sample of the next window, judged against the level being captured.
  assign new_ref_ext = {{WIN_LOG2{1'b0}}, s_slave ^ cap_high};

  assign cap_low    = (mis_cnt <= GLITCH_LIM);
  assign cap_high   = (mis_cnt >= HIGH_LIM);
  assign win_bad    = (mis_cnt > GLITCH_LIM);
  assign bad_next   = (bad_win_cnt == 4'hF) ? 4'hF : bad_win_cnt + 4'd1;
  assign retry_next = retry_cnt + 4'd1;

  assign state_dbg = state;

  always_ff @(posedge PCLK_Master or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      slave_sync    <= '0;
      lock_sync     <= '0;
      ack_sync      <= '0;
      win_cnt       <= '0;
      win_done      <= 1'b0;
      mis_cnt       <= '0;
      settle_cnt    <= '0;
      retry_cnt     <= '0;
      lock_ok       <= 1'b0;
      ref_level     <= 1'b0;
      drift_flag    <= 1'b0;
      realign_req   <= 1'b0;
      bad_win_cnt   <= '0;
      peak_mismatch <= '0;
    end else begin
      slave_sync <= {slave_sync[0], PCLK_Slave};
      lock_sync  <= {lock_sync[0], AlignLock};
      ack_sync   <= {ack_sync[0], realign_ack};

      case (state)
        ST_IDLE: begin
          win_cnt     <= '0;
          win_done    <= 1'b0;
          mis_cnt     <= '0;
          settle_cnt  <= '0;
          retry_cnt   <= '0;
          bad_win_cnt <= '0;
          lock_ok     <= 1'b0;
          realign_req <= 1'b0;
          if (s_lock) state <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (!s_lock) begin
            state       <= ST_IDLE;
            bad_win_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state         <= ST_CAPTURE;
            win_cnt       <= '0;
            win_done      <= 1'b0;
            mis_cnt       <= '0;
            retry_cnt     <= '0;
            drift_flag    <= 1'b0;
            peak_mismatch <= '0;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end

        ST_CAPTURE: begin
          if (!s_lock) begin
            state       <= ST_IDLE;
            bad_win_cnt <= '0;
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            win_done <= &win_cnt;
            if (win_done) begin
              if (cap_low || cap_high) begin
                state     <= ST_MONITOR;
                ref_level <= cap_high;
                lock_ok   <= 1'b1;
                mis_cnt   <= new_ref_ext;
              end else if (retry_next == RETRY_LIM) begin
                state       <= ST_REQ;
                realign_req <= 1'b1;
                mis_cnt     <= '0;
              end else begin
                retry_cnt <= retry_next;
                mis_cnt   <= slave_ext;
              end
            end else begin
              mis_cnt <= mis_cnt + slave_ext;
            end
          end
        end

        ST_MONITOR: begin
          // Losing lock wins over a simultaneous window-end decision.
          if (!s_lock) begin
            state       <= ST_IDLE;
            bad_win_cnt <= '0;
            lock_ok     <= 1'b0;
          end else begin
            win_cnt  <= win_cnt + 1'b1;
            win_done <= &win_cnt;
            if (win_done) begin
              mis_cnt <= mon_ext;
              if (mis_cnt > peak_mismatch) peak_mismatch <= mis_cnt;
              if (win_bad) begin
                drift_flag  <= 1'b1;
                bad_win_cnt <= bad_next;
                if (bad_next >= BAD_LIM) begin
                  state       <= ST_REQ;
                  realign_req <= 1'b1;
                  lock_ok     <= 1'b0;
                end
              end else begin
                bad_win_cnt <= '0;
              end
            end else begin
              mis_cnt <= mis_cnt + mon_ext;
            end
          end
        end

        ST_REQ: begin
          // Lock loss is ignored here; the request holds until acknowledged.
          if (s_ack) begin
            state       <= ST_WAIT_DROP;
            realign_req <= 1'b0;
          end
        end

        ST_WAIT_DROP: begin
          realign_req <= 1'b0;
          if (!s_lock && !s_ack) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pclk_lock_monitor.sv
// Bench for pclk_lock_monitor with default parameters (WIN_LOG2=7,
// GLITCH_MAX=4, BAD_WIN_MAX=3, SETTLE_CYC=256, CAP_RETRY=3).
// The driver pushes time-stamped expected output vectors; the monitor pops
// and compares them at the falling edge of the matching cycle.
module tb_pclk_lock_monitor;

  localparam int W = 19;
  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_CAPTURE = 3'd2,
                         S_MONITOR = 3'd3, S_REQ = 3'd4, S_WAIT = 3'd5;
  // Field masks over {lock_ok, ref_level, drift_flag, realign_req,
  //                   bad_win_cnt[3:0], peak_mismatch[7:0], state_dbg[2:0]}
  localparam logic [W-1:0] M_ST    = 19'h00007;
  localparam logic [W-1:0] M_PEAK  = 19'h007F8;
  localparam logic [W-1:0] M_BAD   = 19'h07800;
  localparam logic [W-1:0] M_REQ   = 19'h08000;
  localparam logic [W-1:0] M_DRIFT = 19'h10000;
  localparam logic [W-1:0] M_REF   = 19'h20000;
  localparam logic [W-1:0] M_LOCK  = 19'h40000;
  localparam logic [W-1:0] M_ALL   = 19'h7FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst, PCLK_Slave, AlignLock, realign_ack;
  logic       lock_ok, ref_level, drift_flag, realign_req;
  logic [3:0] bad_win_cnt;
  logic [7:0] peak_mismatch;
  logic [2:0] state_dbg;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pclk_lock_monitor dut (
    .rst(rst), .PCLK_Master(clk), .PCLK_Slave(PCLK_Slave),
    .AlignLock(AlignLock), .realign_ack(realign_ack),
    .lock_ok(lock_ok), .ref_level(ref_level), .drift_flag(drift_flag),
    .realign_req(realign_req), .bad_win_cnt(bad_win_cnt),
    .peak_mismatch(peak_mismatch), .state_dbg(state_dbg)
  );

  logic [W-1:0] act;
  assign act = {lock_ok, ref_level, drift_flag, realign_req, bad_win_cnt,
                peak_mismatch, state_dbg};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           cyc_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] pk(logic l, logic r, logic d, logic q,
                                      logic [3:0] b, logic [7:0] p, logic [2:0] s);
    return {l, r, d, q, b, p, s};
  endfunction

  task automatic expect_at(input int c, input string n,
                           input logic [W-1:0] v, input logic [W-1:0] m);
    cyc_q.push_back(c);
    name_q.push_back(n);
    exp_q.push_back(v);
    mask_q.push_back(m);
  endtask

  int           m_c;
  logic [W-1:0] m_e, m_m;
  string        m_n;

  always @(negedge clk) begin
    while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
      m_c = cyc_q.pop_front();
      m_n = name_q.pop_front();
      m_e = exp_q.pop_front();
      m_m = mask_q.pop_front();
      checks++;
      if (m_c != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", m_n, m_c, cyc);
      end else if ((act & m_m) !== (m_e & m_m)) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h expected %h (mask %h)",
                 m_n, cyc, act & m_m, m_e & m_m, m_m);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n mismatching samples in the middle of monitor window w
  task automatic inject(input int cap, input int w, input int n, input logic lvl);
    if (n > 0) begin
      goto(cap + 128 * w + 40);
      PCLK_Slave = lvl;
      goto(cap + 128 * w + 40 + n);
      PCLK_Slave = ~lvl;
    end
  endtask

  // ---------------- stimulus ----------------
  int p, c, x, a, d, q;
  int t3_mis[8];

  initial begin
    rst = 1'b1; AlignLock = 1'b0; realign_ack = 1'b0; PCLK_Slave = 1'b1;
    goto(2);
    expect_at(3, "reset_values", pk(0, 0, 0, 0, 0, 0, S_IDLE), M_ALL);
    goto(4);
    rst = 1'b0;

    // Test 1: slave tied high, lock, quiet for 10 windows, drop mid-MONITOR
    p = 10; c = p + 259;
    expect_at(p + 2, "t1_not_settled", pk(0, 0, 0, 0, 0, 0, S_IDLE), M_ST);
    expect_at(p + 3, "t1_settle_entry", pk(0, 0, 0, 0, 0, 0, S_SETTLE), M_ST);
    expect_at(c - 1, "t1_settle_last", pk(0, 0, 0, 0, 0, 0, S_SETTLE), M_ST);
    expect_at(c, "t1_capture_entry", pk(0, 0, 0, 0, 0, 0, S_CAPTURE),
              M_ST | M_LOCK | M_REQ | M_DRIFT);
    expect_at(c + 128, "t1_before_lock", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_ST | M_LOCK);
    expect_at(c + 129, "t1_lock_ref1", pk(1, 1, 0, 0, 0, 0, S_MONITOR), M_ALL);
    expect_at(c + 128 * 11 + 1, "t1_no_drift_10win", pk(1, 1, 0, 0, 0, 0, S_MONITOR), M_ALL);
    x = c + 128 * 11 + 5;
    expect_at(x + 2, "t1_drop_still_mon", pk(1, 1, 0, 0, 0, 0, S_MONITOR), M_LOCK | M_ST);
    expect_at(x + 3, "t1_drop_idle", pk(0, 0, 0, 0, 0, 0, S_IDLE),
              M_ALL & ~M_REF);
    goto(p); AlignLock = 1'b1;
    goto(x); AlignLock = 1'b0;

    // Test 2: lock at ref 0, three windows of 5 mismatches -> request, ack
    goto(x + 5); PCLK_Slave = 1'b0;
    p = x + 10; c = p + 259;
    a = c + 128 * 4 + 1 + 10;
    d = a + 20;
    expect_at(c + 129, "t2_lock_ref0", pk(1, 0, 0, 0, 0, 0, S_MONITOR), M_ALL);
    expect_at(c + 256, "t2_w1_pre", pk(1, 0, 0, 0, 0, 0, S_MONITOR), M_DRIFT | M_BAD);
    expect_at(c + 257, "t2_w1_bad", pk(1, 0, 1, 0, 1, 5, S_MONITOR), M_ALL);
    expect_at(c + 385, "t2_w2_bad", pk(1, 0, 1, 0, 2, 5, S_MONITOR), M_ALL);
    expect_at(c + 512, "t2_w3_pre", pk(1, 0, 1, 0, 2, 5, S_MONITOR), M_REQ | M_BAD | M_ST);
    expect_at(c + 513, "t2_req", pk(0, 0, 1, 1, 3, 5, S_REQ), M_ALL);
    expect_at(a + 2, "t2_ack_hold", pk(0, 0, 0, 1, 0, 0, S_REQ), M_REQ | M_ST);
    expect_at(a + 3, "t2_ack_drop", pk(0, 0, 0, 0, 0, 0, S_WAIT), M_REQ | M_ST | M_LOCK);
    expect_at(d + 2, "t2_wait_drop", pk(0, 0, 0, 0, 0, 0, S_WAIT), M_REQ | M_ST);
    expect_at(d + 3, "t2_back_idle", pk(0, 0, 0, 0, 0, 0, S_IDLE), M_REQ | M_ST);
    goto(p); AlignLock = 1'b1;
    for (int w = 1; w <= 3; w++) inject(c, w, 5, 1'b1);
    goto(a); realign_ack = 1'b1;
    goto(d); realign_ack = 1'b0; AlignLock = 1'b0;

    // Test 3: bad, bad, exactly-4 (good), then bad x3 with lock dropped on
    // the third window end
    t3_mis = '{0, 6, 7, 4, 0, 5, 5, 5};
    p = d + 10; c = p + 259;
    expect_at(c - 1, "t3_drift_kept", pk(0, 0, 1, 0, 0, 5, S_SETTLE), M_DRIFT | M_PEAK | M_ST);
    expect_at(c, "t3_capture_clears", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_DRIFT | M_PEAK | M_ST);
    expect_at(c + 129, "t3_lock", pk(1, 0, 0, 0, 0, 0, S_MONITOR), M_ALL);
    expect_at(c + 257, "t3_w1_bad", pk(1, 0, 1, 0, 1, 6, S_MONITOR), M_ALL);
    expect_at(c + 385, "t3_w2_bad", pk(1, 0, 1, 0, 2, 7, S_MONITOR), M_ALL);
    expect_at(c + 513, "t3_w3_four_good", pk(1, 0, 1, 0, 0, 7, S_MONITOR), M_ALL);
    expect_at(c + 641, "t3_w4_clean", pk(1, 0, 1, 0, 0, 7, S_MONITOR), M_ALL);
    expect_at(c + 769, "t3_w5_bad", pk(1, 0, 1, 0, 1, 7, S_MONITOR), M_ALL);
    expect_at(c + 897, "t3_w6_bad", pk(1, 0, 1, 0, 2, 7, S_MONITOR), M_ALL);
    expect_at(c + 1024, "t3_w7_pre", pk(1, 0, 1, 0, 2, 7, S_MONITOR), M_ALL);
    expect_at(c + 1025, "t3_drop_wins", pk(0, 0, 1, 0, 0, 7, S_IDLE), M_ALL);
    expect_at(c + 1030, "t3_no_req", pk(0, 0, 1, 0, 0, 7, S_IDLE), M_REQ | M_ST);
    goto(p); AlignLock = 1'b1;
    for (int w = 1; w <= 7; w++) inject(c, w, t3_mis[w], 1'b1);
    goto(c + 1022); AlignLock = 1'b0;

    // Test 4: 50% toggling slave -> three ambiguous captures -> request;
    // Test 5: asynchronous reset while in REQ
    p = c + 1035; c = p + 259; q = c + 400;
    expect_at(c, "t4_capture", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_ST | M_DRIFT | M_PEAK);
    expect_at(c + 129, "t4_retry1", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_LOCK | M_ST | M_REQ);
    expect_at(c + 257, "t4_retry2", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_LOCK | M_ST | M_REQ);
    expect_at(c + 384, "t4_pre_req", pk(0, 0, 0, 0, 0, 0, S_CAPTURE), M_LOCK | M_ST | M_REQ);
    expect_at(c + 385, "t4_req", pk(0, 0, 0, 1, 0, 0, S_REQ), M_ALL & ~M_REF);
    expect_at(q - 1, "t5_req_held", pk(0, 0, 0, 1, 0, 0, S_REQ), M_REQ | M_ST);
    expect_at(q, "t5_async_reset", pk(0, 0, 0, 0, 0, 0, S_IDLE), M_ALL);
    expect_at(q + 5, "t5_after_reset", pk(0, 0, 0, 0, 0, 0, S_IDLE), M_ALL);
    goto(p); AlignLock = 1'b1;
    for (int k = p; k < q; k++) begin
      goto(k);
      PCLK_Slave = ~PCLK_Slave;
    end
    goto(q);
    rst = 1'b1; AlignLock = 1'b0; PCLK_Slave = 1'b0;
    goto(q + 3); rst = 1'b0;
    goto(q + 6);

    for (int i = 0; i < 1000 && cyc_q.size() > 0; i++) @(posedge clk);
    if (cyc_q.size() > 0) begin
      errors += cyc_q.size();
      $display("FAIL drain: %0d expected entries never compared", cyc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
